oport_rr_arb: RTL

- Per-output-direction arbiter for the mesh router.
- Five input-buffer controllers (N, W, S, E, B) each raise one request bit for this output. The block grants one of them round-robin, muxes the granted payload onto the output buffer write port, and holds the grant until the output buffer accepts.
- One instance per output direction. Its gnt bits feed the input controllers' arb_gnt; its obuf_rdy input is also fanned to those controllers.

---
 rtl/oport_rr_arb_pkg.sv | 18 +
 rtl/oport_rr_arb_rr_pick5.sv | 25 ++
 rtl/oport_rr_arb.sv | 114 +++++++++++
 3 files changed

// File: rtl/oport_rr_arb_pkg.sv
// Shared router definitions: direction indices, default payload width and
// the arbiter state encoding.
package oport_rr_arb_pkg;

    localparam int DIR_N      = 0;
    localparam int DIR_W      = 1;
    localparam int DIR_S      = 2;
    localparam int DIR_E      = 3;
    localparam int DIR_B      = 4;
    localparam int NUM_DIR    = 5;
    localparam int PYLD_W_DEF = 23;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/oport_rr_arb_rr_pick5.sv
// Round-robin pick over five requesters: one-hot of the first set mask bit
// found scanning start, start+1, ... modulo five. start must be 0..4.
module rr_pick5
    import oport_rr_arb_pkg::*;
(
    input  logic [NUM_DIR-1:0] mask,
    input  logic [2:0]         start,
    output logic [NUM_DIR-1:0] onehot
);

    logic [2*NUM_DIR-1:0] dbl;
    logic [2*NUM_DIR-1:0] rot;
    logic [NUM_DIR-1:0]   rot_lo;
    logic [NUM_DIR-1:0]   pick_r;
    logic [2*NUM_DIR-1:0] unrot;

    // Rotate so 'start' lands at bit 0, take the lowest set bit, rotate back.
    assign dbl    = {mask, mask};
    assign rot    = dbl >> start;
    assign rot_lo = rot[NUM_DIR-1:0];
    assign pick_r = rot_lo & (~rot_lo + {{(NUM_DIR-1){1'b0}}, 1'b1});
    assign unrot  = {{NUM_DIR{1'b0}}, pick_r} << start;
    assign onehot = unrot[NUM_DIR-1:0] | unrot[2*NUM_DIR-1:NUM_DIR];

endmodule

// File: rtl/oport_rr_arb.sv
// Per-output-direction round-robin arbiter: grants one of five input
// controllers, muxes its payload to the output buffer and holds until accepted.
module oport_rr_arb
    import oport_rr_arb_pkg::*;
#(
    parameter int PYLD_W    = PYLD_W_DEF,
    parameter int STALL_MAX = 255,
    parameter int CNT_W     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_DIR-1:0]        port_en,
    input  logic [NUM_DIR-1:0]        req,
    input  logic [NUM_DIR*PYLD_W-1:0] payload_i,
    input  logic                      obuf_rdy,
    output logic [NUM_DIR-1:0]        gnt,
    output logic                      obuf_vld,
    output logic [PYLD_W-1:0]         payload_o,
    output logic                      stall,
    output logic                      busy
);

    localparam logic [CNT_W-1:0] STALL_TH = CNT_W'(STALL_MAX);

    arb_state_e         state;
    logic [2:0]         ptr;
    logic [2:0]         gidx;
    logic [2:0]         nxt_ptr;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_DIR-1:0] ereq;
    logic [NUM_DIR-1:0] b2b_mask;
    logic [NUM_DIR-1:0] idle_oh;
    logic [NUM_DIR-1:0] b2b_oh;
    logic               held;
    logic               xfer;

    assign ereq     = req & port_en;
    assign held     = |(gnt & ereq);
    assign xfer     = held & obuf_rdy;
    assign obuf_vld = xfer;
    assign busy     = (state == ST_BUSY);
    // The just-served input still requests next cycle, so it sits out the pick.
    assign b2b_mask = ereq & ~gnt;
    assign nxt_ptr  = (gidx == 3'(NUM_DIR - 1)) ? 3'd0 : gidx + 3'd1;

    always_comb begin
        gidx      = '0;
        payload_o = '0;
        for (int k = 0; k < NUM_DIR; k++) begin
            if (gnt[k]) begin
                gidx      = 3'(k);
                payload_o = payload_o | payload_i[k*PYLD_W +: PYLD_W];
            end
        end
    end

    rr_pick5 u_pick_idle (
        .mask   (ereq),
        .start  (ptr),
        .onehot (idle_oh)
    );

    rr_pick5 u_pick_b2b (
        .mask   (b2b_mask),
        .start  (nxt_ptr),
        .onehot (b2b_oh)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            gnt   <= '0;
            ptr   <= '0;
            cnt   <= '0;
            stall <= 1'b0;
        end else begin
            stall <= (cnt >= STALL_TH);
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (|ereq) begin
                        gnt   <= idle_oh;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (xfer) begin
                        ptr <= nxt_ptr;
                        cnt <= '0;
                        if (|b2b_mask) begin
                            gnt <= b2b_oh;
                        end else begin
                            gnt   <= '0;
                            state <= ST_IDLE;
                        end
                    end else begin
                        if (cnt != '1)
                            cnt <= cnt + CNT_W'(1);
                        // Request vanished under us: drop without moving ptr.
                        if (!held) begin
                            gnt   <= '0;
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    gnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
